ram_fmi_pp: RTL and testbench
=============================

Name: ram_fmi_pp

Overview:
Parametrised multi-bank (ping-pong by default) input feature-map tile buffer. It replaces the single-bank FMI RAM so the DMA fill side can load tile N+1 while the compute side reads tile N. Banks rotate as a circular queue, with tile-level handshakes on both sides. The block sits between the external-memory loader and the IRB compute datapath.

Parameters:
PX_W, 16, pixel width in bits (package default)
N_ELEM, FMI_N_ELEM, pixels per bank (one tile)
N_BANK, 2, number of banks; must be at least 2
ADDR_W, $clog2(N_ELEM+1), address width; one spare code allows out-of-range detection

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write pixel into the current fill bank
wr_addr  in  ADDR_W  write address
wr_data  in  PX_W  write data
wr_done  in  1  pulse: current fill bank is complete; hand it to the reader
fill_rdy  out  1  a free bank is available for filling
rd_en  in  1  read pixel from the current read bank
rd_addr  in  ADDR_W  read address
rd_data  out  PX_W  registered read data
rd_valid  out  1  rd_data is valid this cycle
rd_done  in  1  pulse: reader releases the current read bank
tile_rdy  out  1  a filled bank is available for reading
err_oob  out  1  sticky: an out-of-range address was used

Behaviour:
- Reset is synchronous and active-low, sampled on posedge clk.
  - Reset values: wr_ptr=0, rd_ptr=0, cnt=0, rd_data=0, rd_valid=0, err_oob=0.
  - Memory contents are not reset.
- State:
  - wr_ptr and rd_ptr each range 0..N_BANK-1 and wrap from N_BANK-1 to 0.
  - cnt (filled banks) ranges 0..N_BANK.
- Outputs are combinational from cnt: fill_rdy = (cnt < N_BANK); tile_rdy = (cnt > 0).
- Write, effective when wr_en & fill_rdy & (wr_addr < N_ELEM):
  - Performs mem[wr_ptr][wr_addr] <= wr_data.
  - wr_en while fill_rdy=0 is dropped silently; no error is flagged.
- wr_done & fill_rdy:
  - wr_ptr++, cnt++.
  - A write in the same cycle lands in the old bank.
  - wr_done while fill_rdy=0 is ignored.
- Read, when rd_en & tile_rdy:
  - 1-cycle latency: rd_data <= mem[rd_ptr][rd_addr] and rd_valid <= 1 on the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its previous value.
  - rd_en while tile_rdy=0 gives rd_valid=0 on the next cycle.
- rd_done & tile_rdy:
  - rd_ptr++, cnt--.
  - A read issued in the same cycle uses the old bank; its data still returns next cycle.
  - rd_done while tile_rdy=0 is ignored.
- Simultaneous accepted wr_done and rd_done: both pointers advance and cnt is unchanged.
- Bank exclusivity:
  - When 0 < cnt < N_BANK, wr_ptr != rd_ptr.
  - When cnt = 0 or N_BANK, only one side is enabled.
  - Reads and writes therefore never target the same bank in the same cycle, and no bypass path is needed.
- Out of range (addr >= N_ELEM) on an otherwise-accepted access:
  - A write is dropped.
  - A read returns rd_data=0 with rd_valid=1.
  - err_oob <= 1 and stays set until reset.
- Reset mid-operation: all tiles are discarded (cnt=0) and any in-flight read is lost (rd_valid=0 next cycle).

Decomposition:
- irb_pkg additions:
  - FMI_N_BANK (=2).
  - FMI_ADDR_W = $clog2(FMI_N_ELEM+1).
  - The existing PX_W and FMI_N_ELEM.
- Sub-module ram_fmi_bank:
  - One bank, single port, synchronous write, registered 1-cycle read.
  - Instantiated N_BANK times via a generate loop.
- The top level holds the pointers, cnt, OOB check, output mux and rd_valid pipeline.

Test Plan:
- N_ELEM=16: write addr i = i for i=0..15, then wr_done -> cnt=1, tile_rdy=1, fill_rdy=1. Read addr 5 -> rd_data=5, rd_valid=1 exactly one cycle later.
- Fill bank0 (0x00..0x0F) and bank1 (0x10..0x1F) with wr_done after each -> fill_rdy=0. Write 0xFF to addr 0 -> dropped. Read bank0 addr 0 -> 0x00. rd_done, read addr 0 -> 0x10.
- cnt=1 with bank1 being filled: assert wr_done and rd_done in the same cycle -> cnt stays 1, wr_ptr=0, rd_ptr=1. Read addr 3 -> bank1 value.
- Write to addr 16 -> no memory change, err_oob=1. Read addr 20 with tile_rdy -> rd_data=0, rd_valid=1. err_oob stays 1 until rst_n=0.
- Boundary handshakes:
  - rd_en with cnt=0 -> rd_valid=0.
  - rd_done with cnt=0 -> cnt stays 0.
  - wr_done with cnt=2 -> cnt stays 2.
- Pull rst_n low for one cycle mid-fill with cnt=1 and rd_en active -> next cycle cnt=0, rd_valid=0, rd_data=0, fill_rdy=1, tile_rdy=0.

Source files
------------

// File: rtl/irb_pkg.sv
// Shared sizing constants for the IRB input-feature-map buffering path.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Contents:
//   PX_W        pixel width in bits
//   FMI_N_ELEM  pixels per FMI tile (one bank)
//   FMI_N_BANK  number of FMI tile banks (ping-pong by default)
//   FMI_ADDR_W  FMI address width; one spare code above the last pixel so that
//               out-of-range addresses remain detectable
package irb_pkg;

    localparam int PX_W       = 16;
    localparam int FMI_N_ELEM = 16;
    localparam int FMI_N_BANK = 2;
    localparam int FMI_ADDR_W = $clog2(FMI_N_ELEM + 1);

endpackage

// File: rtl/ram_fmi_bank.sv
// One FMI tile bank: single-port storage, synchronous write, registered read.
// Latency: read data appears on rdata one cycle after re; it holds otherwise.
// Backpressure: none; the caller guarantees we and re are never both set.
//
// Ports:
//   clk    clock
//   we     write strobe; waddr/wdata are captured on the rising edge
//   waddr  write pixel index (always < N_ELEM)
//   wdata  write pixel
//   re     read strobe; raddr is looked up on the rising edge
//   raddr  read pixel index (always < N_ELEM)
//   rdata  registered read data, updated only when re was set
module ram_fmi_bank #(
    parameter int PX_W   = 16,
    parameter int N_ELEM = 16,
    parameter int AW     = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [PX_W-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [PX_W-1:0] rdata
);

    // Storage is deliberately not reset so it can map onto RAM macros.
    logic [PX_W-1:0] mem [0:N_ELEM-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fmi_pp.sv
// Multi-bank FMI tile buffer: DMA fills one bank while compute reads another.
// Latency: one cycle from accepted rd_en to rd_data/rd_valid.
// Backpressure: fill_rdy low when every bank is full, tile_rdy low when none
//               is; accesses and handshakes on a not-ready side are ignored.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data      pixel write into the current fill bank
//   wr_done                    fill bank complete, hand it to the reader
//   fill_rdy                   a free bank is available for filling
//   rd_en/rd_addr              pixel read from the current read bank
//   rd_data/rd_valid           read result, one cycle after rd_en
//   rd_done                    reader releases the current read bank
//   tile_rdy                   a filled bank is available for reading
//   err_oob                    sticky flag: an out-of-range address was used
module ram_fmi_pp #(
    parameter int PX_W   = irb_pkg::PX_W,
    parameter int N_ELEM = irb_pkg::FMI_N_ELEM,
    parameter int N_BANK = irb_pkg::FMI_N_BANK,
    parameter int ADDR_W = $clog2(N_ELEM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PX_W-1:0]   wr_data,
    input  logic              wr_done,
    output logic              fill_rdy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PX_W-1:0]   rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              tile_rdy,
    output logic              err_oob
);

    // N_BANK must be at least 2; with a single bank fill and read could never overlap.
    localparam int PTR_W = $clog2(N_BANK);
    localparam int CNT_W = $clog2(N_BANK + 1);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(N_ELEM);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_BANK);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(N_BANK - 1);

    // Circular-queue state: wr_ptr is the bank being filled, rd_ptr the bank
    // being read, cnt the number of filled banks waiting for or held by the reader.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Read-return pipeline: which bank answers, whether the answer is forced
    // to zero, and the last presented value so rd_data holds between reads.
    logic [PTR_W-1:0] rd_sel;
    logic             rd_oob;
    logic [PX_W-1:0]  rd_hold;

    logic wr_acc, rd_acc;
    logic wr_inr, rd_inr;
    logic wr_ok,  rd_ok;
    logic fill_adv, read_adv;

    logic [PX_W-1:0] bank_q [N_BANK];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fill_rdy = (cnt < CNT_FULL);
    assign tile_rdy = (cnt != '0);

    assign wr_acc = wr_en & fill_rdy;
    assign rd_acc = rd_en & tile_rdy;
    assign wr_inr = (wr_addr < ADDR_LIM);
    assign rd_inr = (rd_addr < ADDR_LIM);
    assign wr_ok  = wr_acc & wr_inr;
    assign rd_ok  = rd_acc & rd_inr;

    assign fill_adv = wr_done & fill_rdy;
    assign read_adv = rd_done & tile_rdy;

    // Fill and read banks differ whenever both sides are enabled, so a bank
    // never sees a write and a read in the same cycle and no bypass is needed.
    for (genvar g = 0; g < N_BANK; g++) begin : g_bank
        ram_fmi_bank #(
            .PX_W   (PX_W),
            .N_ELEM (N_ELEM),
            .AW     (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (wr_ok && (wr_ptr == PTR_W'(g))),
            .waddr (wr_addr[IDX_W-1:0]),
            .wdata (wr_data),
            .re    (rd_ok && (rd_ptr == PTR_W'(g))),
            .raddr (rd_addr[IDX_W-1:0]),
            .rdata (bank_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (fill_adv) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (read_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous hand-over and release leaves the occupancy unchanged.
            case ({fill_adv, read_adv})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // rd_sel captures the pre-advance rd_ptr, so a read issued together with
    // rd_done still returns data from the bank being released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
            rd_sel   <= '0;
            rd_hold  <= '0;
            err_oob  <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_oob <= ~rd_inr;
                rd_sel <= rd_ptr;
            end
            if (rd_valid) begin
                rd_hold <= rd_data;
            end
            if ((wr_acc & ~wr_inr) | (rd_acc & ~rd_inr)) begin
                err_oob <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = rd_hold;
        if (rd_valid) begin
            rd_data = rd_oob ? '0 : bank_q[rd_sel];
        end
    end

endmodule

// File: tb/tb_ram_fmi_pp.sv
// Directed self-checking bench for ram_fmi_pp (N_ELEM=16, N_BANK=2, PX_W=16).
// Latency: inputs applied #1 after a rising edge, outputs sampled #1 after the next.
// Backpressure: exercised through the fill_rdy/tile_rdy boundary cases.
module tb_ram_fmi_pp;

    localparam int PX_W   = 16;
    localparam int N_ELEM = 16;
    localparam int N_BANK = 2;
    localparam int ADDR_W = $clog2(N_ELEM + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PX_W-1:0]   wr_data;
    logic              wr_done;
    logic              fill_rdy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PX_W-1:0]   rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              tile_rdy;
    logic              err_oob;

    int checks   = 0;
    int failures = 0;

    ram_fmi_pp #(
        .PX_W   (PX_W),
        .N_ELEM (N_ELEM),
        .N_BANK (N_BANK),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .fill_rdy (fill_rdy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_done  (rd_done),
        .tile_rdy (tile_rdy),
        .err_oob  (err_oob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [PX_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic pulse_wr_done();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic pulse_rd_done();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        idle();
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_fill_rdy", fill_rdy, 1);
        chk("rst_tile_rdy", tile_rdy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data",  rd_data,  0);
        chk("rst_err_oob",  err_oob,  0);

        // Boundary: read side idle with no tiles
        rd(5'd3);
        chk("rd_en_empty_valid", rd_valid, 0);
        pulse_rd_done();
        chk("rd_done_empty_cnt", dut.cnt, 0);
        chk("rd_done_empty_rdptr", dut.rd_ptr, 0);

        // Bank0 = i, hand over
        for (int i = 0; i < N_ELEM; i++) wr(ADDR_W'(i), PX_W'(i));
        pulse_wr_done();
        chk("fill0_cnt", dut.cnt, 1);
        chk("fill0_tile_rdy", tile_rdy, 1);
        chk("fill0_fill_rdy", fill_rdy, 1);

        // One-cycle read latency
        chk("pre_read_valid", rd_valid, 0);
        rd(5'd5);
        chk("rd5_valid", rd_valid, 1);
        chk("rd5_data", rd_data, 16'h0005);
        tick();
        chk("rd5_valid_drop", rd_valid, 0);
        chk("rd5_data_hold", rd_data, 16'h0005);

        // Bank1 = 0x10+i, both banks full
        for (int i = 0; i < N_ELEM; i++) wr(ADDR_W'(i), PX_W'(16'h10 + i));
        pulse_wr_done();
        chk("full_fill_rdy", fill_rdy, 0);
        chk("full_cnt", dut.cnt, 2);

        // Writes and wr_done while full are ignored
        wr(5'd0, 16'h00FF);
        chk("full_wr_no_err", err_oob, 0);
        pulse_wr_done();
        chk("full_wr_done_cnt", dut.cnt, 2);
        chk("full_wr_done_wrptr", dut.wr_ptr, 0);
        rd(5'd0);
        chk("bank0_a0_not_overwritten", rd_data, 16'h0000);

        // Release bank0, bank1 becomes the read bank
        pulse_rd_done();
        chk("rel0_cnt", dut.cnt, 1);
        chk("rel0_fill_rdy", fill_rdy, 1);
        rd(5'd0);
        chk("bank1_a0", rd_data, 16'h0010);

        // Refill bank0 = 0x20+i while bank1 is being read
        for (int i = 0; i < N_ELEM - 1; i++) wr(ADDR_W'(i), PX_W'(16'h20 + i));

        // Same cycle: last write, wr_done, read addr 3, rd_done
        wr_en   = 1'b1;
        wr_addr = 5'd15;
        wr_data = 16'h00AB;
        wr_done = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 5'd3;
        rd_done = 1'b1;
        tick();
        idle();
        chk("simul_rd_old_bank_valid", rd_valid, 1);
        chk("simul_rd_old_bank_data", rd_data, 16'h0013);
        chk("simul_cnt", dut.cnt, 1);
        chk("simul_wrptr", dut.wr_ptr, 1);
        chk("simul_rdptr", dut.rd_ptr, 0);
        rd(5'd3);
        chk("bank0_a3", rd_data, 16'h0023);
        rd(5'd15);
        chk("write_with_wr_done_old_bank", rd_data, 16'h00AB);

        // Out-of-range accesses (fill bank is bank1)
        wr(5'd16, 16'h5555);
        chk("oob_wr_err", err_oob, 1);
        rd(5'd20);
        chk("oob_rd_valid", rd_valid, 1);
        chk("oob_rd_data", rd_data, 16'h0000);
        chk("oob_err_sticky", err_oob, 1);

        // Drain, then boundary handshakes with cnt=0
        pulse_rd_done();
        chk("drain_cnt", dut.cnt, 0);
        chk("drain_tile_rdy", tile_rdy, 0);
        pulse_rd_done();
        chk("rd_done_empty2_cnt", dut.cnt, 0);
        chk("rd_done_empty2_rdptr", dut.rd_ptr, 1);

        // Hand bank1 over untouched; the OOB write must not have aliased to addr 0
        pulse_wr_done();
        rd(5'd0);
        chk("oob_wr_no_alias", rd_data, 16'h0010);
        chk("err_still_set", err_oob, 1);

        // Reset mid-fill with cnt=1 and a read in flight
        wr(5'd2, 16'h0077);
        rd_en   = 1'b1;
        rd_addr = 5'd1;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        chk("mrst_cnt", dut.cnt, 0);
        chk("mrst_rd_valid", rd_valid, 0);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_fill_rdy", fill_rdy, 1);
        chk("mrst_tile_rdy", tile_rdy, 0);
        chk("mrst_err_oob", err_oob, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
